vc_pwm_modulator: RTL and testbench
===================================

// Module: vc_pwm_modulator
// PURPOSE
//  Receiving end of the PI controller output. Takes the signed Q8.24 control voltage vc and
//  converts it to an edge-aligned PWM duty cycle. Drives a complementary high/low gate pair
//  with dead time. Emits a period_start strobe so the estimator/PI sampling stays in lock-step
//  with the carrier.
// PARAMETERS
//  PERIOD    1000          carrier period in clk cycles; also full-scale compare value
//  CNT_W     16            counter/compare width; PERIOD < 2**CNT_W
//  GAIN      32'h0032_0000 unsigned Q16.16 counts per volt (50.0 -> +/-10 V spans 0..PERIOD)
//  DEADTIME  10            clk cycles both outputs are held low on each transition, >=1
// PORTS
//  clk          in   1      system clock
//  rst          in   1      reset
//  en           in   1      modulator enable; 0 forces both gate outputs low
//  vc           in   32     signed Q8.24 control voltage
//  vc_valid     in   1      capture strobe for vc; may be high every cycle
//  pwm_h        out  1      high-side gate
//  pwm_l        out  1      low-side gate
//  period_start out  1      1-cycle pulse when the counter is 0 (new compare active)
//  sat          out  1      last captured vc was clamped to 0 or PERIOD
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. rst=0 immediately forces
//    pwm_h=pwm_l=period_start=sat=0, cnt=0, shadow_cmp=active_cmp=PERIOD/2, FSM=IDLE.
//    This applies even mid-period.
//  - Scaling pipeline, 2 stages. S1: prod = vc * {1'b0,GAIN}, 64-bit signed, Q24.40.
//    S2: d = ((prod + 2**39) >>> 40) + PERIOD/2, signed and rounded half-up.
//    Clamp d to [0,PERIOD], register into shadow_cmp, set sat if the clamp acted.
//  - shadow_cmp and sat update 2 cycles after vc_valid. Back-to-back strobes are allowed;
//    the most recent one wins.
//  - Counter: cnt counts 0..PERIOD-1 and wraps to 0 while en=1. It holds at 0 while en=0.
//  - period_start=1 in every cycle where cnt==0 and en=1. On that edge active_cmp<=shadow_cmp.
//    A value still in the pipeline on that edge waits for the next period (no partial update).
//  - raw = en & (cnt < active_cmp). This is exact: duty = active_cmp/PERIOD.
//    cmp=0 gives always low; cmp=PERIOD gives always high.
//  - Dead-time FSM, outputs registered:
//      IDLE  (h=0,l=0): en=1 -> DT_L.
//      DT_L  (0,0): dt counter counts DEADTIME cycles, then -> LON.
//                   If raw=1 arrives first -> DT_H with the counter cleared.
//      LON   (0,1): raw=1 -> DT_H, counter cleared.
//      DT_H  (0,0): dt counter counts DEADTIME cycles, then -> HON.
//                   If raw=0 arrives first -> DT_L with the counter cleared.
//      HON   (1,0): raw=0 -> DT_L, counter cleared.
//      Any state with en=0 -> IDLE on the next edge; outputs low in that same cycle.
//  - Invariant: pwm_h & pwm_l is never 1. A raw pulse shorter than DEADTIME never reaches
//    the gate it targets.
//  - sat is held until the next S2 update; rst clears it.
// STRUCTURE
//  - Shared package ctrl_pkg: Q8.24 format constants (Q_INT=8, Q_FRAC=24), VMAX=32'sh0A00_0000,
//    VMIN=32'shF600_0000, and the dead-time FSM state encoding (IDLE, DT_L, LON, DT_H, HON).
//  - Sub-module pwm_deadtime: inputs raw/en and parameter DEADTIME; outputs pwm_h/pwm_l.
//    Contains the FSM and the dt counter.
//  - Top level holds the scaling pipeline, shadow/active compare, counter and period_start.
// TESTING
//  1. rst=0 asserted mid-period with pwm_h=1 -> pwm_h=pwm_l=period_start=sat=0 in the same
//     cycle, with no clock edge.
//  2. en=1, vc=32'h0000_0000 -> cmp=500. Per 1000-cycle period: pwm_h high 490 cycles,
//     pwm_l high 490 cycles, two 10-cycle both-low gaps.
//  3. vc=32'h0A00_0000 (+10 V) -> cmp=1000, sat=0, pwm_h constantly 1.
//     vc=32'h0C00_0000 (+12 V) -> cmp=1000, sat=1.
//  4. vc=32'hF600_0000 (-10 V) -> cmp=0, pwm_l constantly 1, pwm_h 0.
//     vc=32'hF400_0000 -> sat=1.
//  5. vc_valid at cnt=300 changes cmp 500->750 -> duty stays 500 until the next period_start,
//     then becomes 750. A strobe at cnt=999 takes effect one period later.
//  6. vc giving cmp=5 -> pwm_h never asserts; pwm_l is low 15 cycles per period.
//     Check every cycle: pwm_h & pwm_l == 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared controller definitions: Q8.24 voltage format and the gate dead-time FSM encoding.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package ctrl_pkg;

    // Control voltage format, signed Q8.24
    localparam int Q_INT  = 8;
    localparam int Q_FRAC = 24;
    localparam int Q_W    = Q_INT + Q_FRAC;

    typedef logic signed [Q_W-1:0] q8_24_t;

    // Nominal control voltage range, +/-10 V
    localparam q8_24_t VMAX = 32'sh0A00_0000;
    localparam q8_24_t VMIN = 32'shF600_0000;

    // Gate dead-time FSM: both-low wait states sit between every on-state change
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DT_L = 3'd1,
        LON  = 3'd2,
        DT_H = 3'd3,
        HON  = 3'd4
    } dt_state_t;

endpackage

// File: rtl/vc_pwm_modulator_if.sv
// Control-voltage in / gate drive out bundle of the PWM modulator.
// Latency: none (wiring only).
// Backpressure: none; vc_valid is a fire-and-forget strobe, outputs are free-running.
// Ports: en, vc, vc_valid (master -> modulator); pwm_h, pwm_l, period_start, sat (modulator -> master).
interface vc_pwm_modulator_if;

    logic            en;
    ctrl_pkg::q8_24_t vc;
    logic            vc_valid;
    logic            pwm_h;
    logic            pwm_l;
    logic            period_start;
    logic            sat;

    modport master (
        output en, vc, vc_valid,
        input  pwm_h, pwm_l, period_start, sat
    );

    modport slave (
        input  en, vc, vc_valid,
        output pwm_h, pwm_l, period_start, sat
    );

endinterface

// File: rtl/pwm_deadtime.sv
// Turns the raw PWM level into a complementary high/low gate pair with DEADTIME both-low cycles.
// Latency: 1 cycle from raw to gate state change, plus DEADTIME cycles of both-low on each transition.
// Backpressure: none; en=0 drops both gates at once and parks the FSM in IDLE.
// Ports: clk, rst (async, active-low), raw, en in; pwm_h, pwm_l out.
module pwm_deadtime
    import ctrl_pkg::*;
#(
    parameter int DEADTIME = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic en,
    output logic pwm_h,
    output logic pwm_l
);

    localparam int              DT_W    = $clog2(DEADTIME + 1);
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME - 1);

    dt_state_t       state, state_n;
    logic [DT_W-1:0] dt_cnt, dt_n;
    logic            h_q, l_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            dt_cnt <= '0;
            h_q    <= 1'b0;
            l_q    <= 1'b0;
        end else begin
            state  <= state_n;
            dt_cnt <= dt_n;
            h_q    <= (state_n == HON);
            l_q    <= (state_n == LON);
        end
    end

    // A raw level that flips back during a wait state restarts the opposite wait,
    // so pulses shorter than DEADTIME never turn on the gate they aim at.
    always_comb begin
        state_n = state;
        dt_n    = dt_cnt;
        if (!en) begin
            state_n = IDLE;
            dt_n    = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = DT_L;
                    dt_n    = '0;
                end
                DT_L: begin
                    if (raw) begin
                        state_n = DT_H;
                        dt_n    = '0;
                    end else if (dt_cnt == DT_LAST) begin
                        state_n = LON;
                        dt_n    = '0;
                    end else begin
                        dt_n = dt_cnt + DT_W'(1);
                    end
                end
                LON: begin
                    if (raw) begin
                        state_n = DT_H;
                        dt_n    = '0;
                    end
                end
                DT_H: begin
                    if (!raw) begin
                        state_n = DT_L;
                        dt_n    = '0;
                    end else if (dt_cnt == DT_LAST) begin
                        state_n = HON;
                        dt_n    = '0;
                    end else begin
                        dt_n = dt_cnt + DT_W'(1);
                    end
                end
                HON: begin
                    if (!raw) begin
                        state_n = DT_L;
                        dt_n    = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    dt_n    = '0;
                end
            endcase
        end
    end

    // en gates the registered outputs so disabling kills the gates in the same cycle
    assign pwm_h = h_q & en;
    assign pwm_l = l_q & en;

endmodule

// File: rtl/vc_pwm_modulator.sv
// Converts the signed Q8.24 control voltage into an edge-aligned PWM compare and dead-timed gate pair.
// Latency: vc_valid -> shadow_cmp/sat 2 cycles; shadow -> active compare at the next period_start.
// Backpressure: none; vc_valid may fire every cycle and the most recent strobe wins.
// Ports: clk, rst (async, active-low), pwm (vc_pwm_modulator_if.slave: en, vc, vc_valid,
//        pwm_h, pwm_l, period_start, sat).
module vc_pwm_modulator
    import ctrl_pkg::*;
#(
    parameter int          PERIOD   = 1000,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] GAIN     = 32'h0032_0000,
    parameter int          DEADTIME = 10
) (
    input  logic              clk,
    input  logic              rst,
    vc_pwm_modulator_if.slave pwm
);

    localparam logic [CNT_W-1:0]   CMP_MID  = CNT_W'(PERIOD / 2);
    localparam logic [CNT_W-1:0]   CMP_MAX  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic signed [63:0] D_MID    = 64'(PERIOD / 2);
    localparam logic signed [63:0] D_MAX    = 64'(PERIOD);
    localparam logic signed [63:0] RND_HALF = 64'sh0000_0080_0000_0000;

    // ---------------- scaling pipeline ----------------
    // S1: Q8.24 volts * Q16.16 counts/volt -> Q24.40 counts. The product is below 2**63
    // in magnitude, so a 64-bit signed multiply of the sign/zero-extended operands is exact.
    logic signed [63:0] vc_ext, gain_ext, prod_d, prod_q;
    logic               s1_vld;

    assign vc_ext   = {{32{pwm.vc[Q_W-1]}}, pwm.vc};
    assign gain_ext = {32'd0, GAIN};
    assign prod_d   = vc_ext * gain_ext;

    // S2: round half-up to whole counts, re-centre on mid-scale, clamp to [0, PERIOD]
    logic signed [63:0] rnd, d;
    logic [CNT_W-1:0]   cmp_d;
    logic               sat_d;

    assign rnd = prod_q + RND_HALF;
    assign d   = (rnd >>> 40) + D_MID;

    always_comb begin
        cmp_d = d[CNT_W-1:0];
        sat_d = 1'b0;
        if (d[63]) begin
            cmp_d = '0;
            sat_d = 1'b1;
        end else if (d > D_MAX) begin
            cmp_d = CMP_MAX;
            sat_d = 1'b1;
        end
    end

    logic [CNT_W-1:0] shadow_cmp;
    logic             sat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld     <= 1'b0;
            prod_q     <= '0;
            shadow_cmp <= CMP_MID;
            sat_q      <= 1'b0;
        end else begin
            s1_vld <= pwm.vc_valid;
            if (pwm.vc_valid) begin
                prod_q <= prod_d;
            end
            if (s1_vld) begin
                shadow_cmp <= cmp_d;
                sat_q      <= sat_d;
            end
        end
    end

    // ---------------- carrier counter ----------------
    // armed is low only in the first cycle after reset release; it keeps period_start
    // (combinational from cnt==0) low for as long as reset is asserted.
    logic             armed;
    logic             cnt_en;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_cmp;
    logic             raw;

    assign cnt_en = pwm.en & armed;
    assign start  = cnt_en & (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed      <= 1'b0;
            cnt        <= '0;
            active_cmp <= CMP_MID;
        end else begin
            armed <= 1'b1;
            if (!cnt_en || cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // whole-period update only: the compare never changes mid-carrier
            if (start) begin
                active_cmp <= shadow_cmp;
            end
        end
    end

    // cmp=0 never matches (always low), cmp=PERIOD always matches (always high)
    assign raw = cnt_en & (cnt < active_cmp);

    pwm_deadtime #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw),
        .en    (pwm.en),
        .pwm_h (pwm.pwm_h),
        .pwm_l (pwm.pwm_l)
    );

    assign pwm.period_start = start;
    assign pwm.sat          = sat_q;

endmodule

// File: tb/tb_vc_pwm_modulator.sv
// Directed bench for vc_pwm_modulator: reset, scaling/clamping, duty and dead time,
// shadow-to-active timing, back-to-back strobes and disable.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vc_pwm_modulator;
    import ctrl_pkg::*;

    localparam int PERIOD = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vc_pwm_modulator_if pif ();

    vc_pwm_modulator #(
        .PERIOD   (PERIOD),
        .CNT_W    (16),
        .GAIN     (32'h0032_0000),
        .DEADTIME (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pwm (pif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // -9.9 V rounded toward zero in Q8.24; scales to exactly 5 counts
    localparam logic [31:0] V_CMP5 = 32'hF619_999A;

    task automatic wait_start();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pif.period_start && k < 3000);
        n_checks++;
        if (pif.period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_start: period_start=%b after %0d cycles, required a pulse", pif.period_start, k);
        end
    endtask

    task automatic measure(output int h, output int l, output int gap, output int ovl);
        h = 0; l = 0; gap = 0; ovl = 0;
        wait_start();
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clk);
            if (pif.pwm_h) h++;
            if (pif.pwm_l) l++;
            if (!pif.pwm_h && !pif.pwm_l) gap++;
            if (pif.pwm_h && pif.pwm_l) ovl++;
        end
    endtask

    task automatic set_vc(input logic [31:0] v);
        @(negedge clk);
        pif.vc       = v;
        pif.vc_valid = 1'b1;
        @(negedge clk);
        pif.vc_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
        wait_start();
        wait_start();
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        pif.en       = 1'b1;
        pif.vc       = '0;
        pif.vc_valid = 1'b0;
        #1;
        n_checks++; if (pif.pwm_h !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_h: got %b expected 0", pif.pwm_h); end
        n_checks++; if (pif.pwm_l !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_l: got %b expected 0", pif.pwm_l); end
        n_checks++; if (pif.period_start !== 1'b0) begin n_fail++; $display("FAIL reset_period_start: got %b expected 0", pif.period_start); end
        n_checks++; if (pif.sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", pif.sat); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        // +12 V: full-scale high with sat set, then reset mid-period
        set_vc(32'h0C00_0000);
        settle();
        wait_start();
        repeat (300) @(negedge clk);
        n_checks++; if (pif.pwm_h !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pwm_h: got %b expected 1", pif.pwm_h); end
        n_checks++; if (pif.sat !== 1'b1) begin n_fail++; $display("FAIL pre_reset_sat: got %b expected 1", pif.sat); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (pif.pwm_h !== 1'b0) begin n_fail++; $display("FAIL async_pwm_h: got %b expected 0", pif.pwm_h); end
        n_checks++; if (pif.pwm_l !== 1'b0) begin n_fail++; $display("FAIL async_pwm_l: got %b expected 0", pif.pwm_l); end
        n_checks++; if (pif.period_start !== 1'b0) begin n_fail++; $display("FAIL async_period_start: got %b expected 0", pif.period_start); end
        n_checks++; if (pif.sat !== 1'b0) begin n_fail++; $display("FAIL async_sat: got %b expected 0", pif.sat); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mid_scale();
        int h, l, gap, ovl;
        set_vc(32'h0000_0000);
        n_checks++; if (pif.sat !== 1'b0) begin n_fail++; $display("FAIL mid_sat: got %b expected 0", pif.sat); end
        settle();
        measure(h, l, gap, ovl);
        n_checks++; if (h !== 490) begin n_fail++; $display("FAIL mid_h_cycles: got %0d expected 490", h); end
        n_checks++; if (l !== 490) begin n_fail++; $display("FAIL mid_l_cycles: got %0d expected 490", l); end
        n_checks++; if (gap !== 20) begin n_fail++; $display("FAIL mid_gap_cycles: got %0d expected 20", gap); end
        n_checks++; if (ovl !== 0) begin n_fail++; $display("FAIL mid_overlap: got %0d expected 0", ovl); end
    endtask

    task automatic test_full_scale();
        int h, l, gap, ovl;
        set_vc(VMAX);
        n_checks++; if (pif.sat !== 1'b0) begin n_fail++; $display("FAIL p10_sat: got %b expected 0", pif.sat); end
        settle();
        measure(h, l, gap, ovl);
        n_checks++; if (h !== 1000) begin n_fail++; $display("FAIL p10_h_cycles: got %0d expected 1000", h); end
        n_checks++; if (l !== 0) begin n_fail++; $display("FAIL p10_l_cycles: got %0d expected 0", l); end
        set_vc(32'h0C00_0000);
        n_checks++; if (pif.sat !== 1'b1) begin n_fail++; $display("FAIL p12_sat: got %b expected 1", pif.sat); end
        measure(h, l, gap, ovl);
        n_checks++; if (h !== 1000) begin n_fail++; $display("FAIL p12_h_cycles: got %0d expected 1000", h); end
    endtask

    task automatic test_zero_scale();
        int h, l, gap, ovl;
        set_vc(VMIN);
        n_checks++; if (pif.sat !== 1'b0) begin n_fail++; $display("FAIL m10_sat: got %b expected 0", pif.sat); end
        settle();
        measure(h, l, gap, ovl);
        n_checks++; if (h !== 0) begin n_fail++; $display("FAIL m10_h_cycles: got %0d expected 0", h); end
        n_checks++; if (l !== 1000) begin n_fail++; $display("FAIL m10_l_cycles: got %0d expected 1000", l); end
        set_vc(32'hF400_0000);
        n_checks++; if (pif.sat !== 1'b1) begin n_fail++; $display("FAIL m12_sat: got %b expected 1", pif.sat); end
    endtask

    task automatic test_shadow_update();
        int h[5];
        int exp_h[5];
        int l1;
        exp_h = '{490, 740, 740, 740, 490};
        l1 = 0;
        set_vc(32'h0000_0000);
        settle();
        for (int p = 0; p < 5; p++) begin
            h[p] = 0;
            for (int i = 0; i < PERIOD; i++) begin
                if (p > 0 || i > 0) @(negedge clk);
                if (i == 0) begin
                    n_checks++;
                    if (pif.period_start !== 1'b1) begin n_fail++; $display("FAIL shadow_start_p%0d: got %b expected 1", p, pif.period_start); end
                end
                if (pif.pwm_h) h[p]++;
                if (p == 1 && pif.pwm_l) l1++;
                // +5 V (cmp 750) at cnt=300, back to 0 V (cmp 500) at cnt=999
                pif.vc_valid = (p == 0 && i == 300) || (p == 2 && i == 999);
                if (p == 0 && i == 300) pif.vc = 32'h0500_0000;
                if (p == 2 && i == 999) pif.vc = 32'h0000_0000;
            end
            n_checks++;
            if (h[p] !== exp_h[p]) begin n_fail++; $display("FAIL shadow_h_p%0d: got %0d expected %0d", p, h[p], exp_h[p]); end
        end
        n_checks++; if (l1 !== 240) begin n_fail++; $display("FAIL shadow_l_p1: got %0d expected 240", l1); end
    endtask

    task automatic test_back_to_back();
        int h, l, gap, ovl;
        @(negedge clk);
        pif.vc = 32'h0C00_0000; pif.vc_valid = 1'b1;
        @(negedge clk);
        pif.vc = V_CMP5;
        @(negedge clk);
        pif.vc_valid = 1'b0;
        n_checks++; if (pif.sat !== 1'b1) begin n_fail++; $display("FAIL b2b_first_sat: got %b expected 1", pif.sat); end
        @(negedge clk);
        n_checks++; if (pif.sat !== 1'b0) begin n_fail++; $display("FAIL b2b_last_sat: got %b expected 0", pif.sat); end
        settle();
        measure(h, l, gap, ovl);
        n_checks++; if (h !== 0) begin n_fail++; $display("FAIL cmp5_h_cycles: got %0d expected 0", h); end
        n_checks++; if (l !== 985) begin n_fail++; $display("FAIL cmp5_l_cycles: got %0d expected 985", l); end
        n_checks++; if (ovl !== 0) begin n_fail++; $display("FAIL cmp5_overlap: got %0d expected 0", ovl); end
    endtask

    task automatic test_disable();
        int hi;
        hi = 0;
        n_checks++; if (pif.pwm_l !== 1'b1) begin n_fail++; $display("FAIL pre_disable_l: got %b expected 1", pif.pwm_l); end
        pif.en = 1'b0;
        #1;
        n_checks++; if (pif.pwm_l !== 1'b0) begin n_fail++; $display("FAIL disable_l_now: got %b expected 0", pif.pwm_l); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pif.pwm_h || pif.pwm_l || pif.period_start) hi++;
        end
        n_checks++; if (hi !== 0) begin n_fail++; $display("FAIL disable_quiet: got %0d active cycles expected 0", hi); end
    endtask

    initial begin
        test_reset();
        test_mid_scale();
        test_full_scale();
        test_zero_scale();
        test_shadow_update();
        test_back_to_back();
        test_disable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
